// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select (branch > jump > stall > sequential)
// and the fetch/decode pipeline register with an accepted-instruction counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc4,
  output logic        valid,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    EdgeBranch,
    EdgeJump,
    EdgeHold,
    EdgeAdvance
  } edge_kind_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc4_q, instr_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_target_aligned;
  edge_kind_e  edge_kind;

  assign pc4                   = pc_q + 32'd4;
  assign jump_target           = {pc4[31:28], jump_index, 2'b00};
  assign branch_target_aligned = branch_target & ~32'h0000_0003;

  always_comb begin
    edge_kind = EdgeAdvance;
    if (branch_taken) begin
      edge_kind = EdgeBranch;
    end else if (jump) begin
      edge_kind = EdgeJump;
    end else if (stall) begin
      edge_kind = EdgeHold;
    end
  end

  // Redirects squash the word fetched at the old PC so it never reaches decode.
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc4_d   = instr_pc4_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    unique case (edge_kind)
      EdgeBranch: begin
        pc_d        = branch_target_aligned;
        instr_d     = 32'h0000_0000;
        instr_pc4_d = 32'h0000_0000;
        valid_d     = 1'b0;
      end
      EdgeJump: begin
        pc_d        = jump_target;
        instr_d     = 32'h0000_0000;
        instr_pc4_d = 32'h0000_0000;
        valid_d     = 1'b0;
      end
      EdgeHold: begin
      end
      EdgeAdvance: begin
        pc_d          = pc4;
        instr_d       = imem_data;
        instr_pc4_d   = pc4;
        valid_d       = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= ResetPcAligned;
      instr_q       <= 32'h0000_0000;
      instr_pc4_q   <= 32'h0000_0000;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc4_q   <= instr_pc4_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc4   = instr_pc4_q;
  assign valid       = valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a fetch model.
module tb_if_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_data, instr, instr_pc4, fetch_count;
  logic        valid;
  logic [31:0] imem_addr2, imem_data2, instr2, instr_pc4_2, fetch_count2;
  logic        valid2;

  int total;
  int bad;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_data  = word_of(imem_addr);
  assign imem_data2 = word_of(imem_addr2);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr), .instr_pc4(instr_pc4),
    .valid(valid), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(32'h1000_0007)) dut2 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .imem_addr(imem_addr2), .imem_data(imem_data2), .instr(instr2), .instr_pc4(instr_pc4_2),
    .valid(valid2), .fetch_count(fetch_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  // One clock edge with the given inputs; model follows the priority rules directly.
  task automatic step(input logic s, input logic b, input logic [31:0] bt, input logic j,
                      input logic [25:0] ji);
    logic [31:0] nxt;
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    if (!reset) begin
      nxt = m_pc + 32'd4;
      if (b || j) begin
        m_pc    = b ? {bt[31:2], 2'b00} : {nxt[31:28], ji, 2'b00};
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = word_of(m_pc); m_pc4 = nxt; m_pc = nxt; m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic free_edge();
    step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    step(1'b0, 1'b1, tgt, 1'b0, 26'h0);
  endtask

  task automatic test_reset();
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;
    reset = 1'b1;
    #2;
    model_reset();
    total++;
    if ({imem_addr, instr, instr_pc4, valid, fetch_count} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0})
    begin
      bad++;
      $display("FAIL reset_state: got pc=%h instr=%h pc4=%h v=%b cnt=%h want all zero",
               imem_addr, instr, instr_pc4, valid, fetch_count);
    end
    total++;
    if (imem_addr2 !== 32'h1000_0004) begin
      bad++;
      $display("FAIL reset_pc_align: got %h want 10000004", imem_addr2);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      free_edge();
      total++;
      if (instr !== word_of(32'(i * 4)) || instr_pc4 !== 32'(i * 4 + 4)) begin
        bad++;
        $display("FAIL seq_fetch[%0d]: got instr=%h pc4=%h want instr=%h pc4=%h", i, instr,
                 instr_pc4, word_of(32'(i * 4)), 32'(i * 4 + 4));
      end
    end
    total++;
    if (imem_addr !== 32'd12 || fetch_count !== 32'd3 || valid !== 1'b1) begin
      bad++;
      $display("FAIL seq_state: got pc=%h cnt=%0d v=%b want pc=0000000c cnt=3 v=1", imem_addr,
               fetch_count, valid);
    end
  endtask

  task automatic test_stall();
    redirect(32'h0000_000C);
    free_edge();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
      total++;
      if (imem_addr !== 32'h10 || instr !== word_of(32'hC) || fetch_count !== 32'd4 ||
          valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h instr=%h cnt=%0d v=%b want pc=10 instr=%h cnt=4",
                 i, imem_addr, instr, fetch_count, valid, word_of(32'hC));
      end
    end
    free_edge();
    total++;
    if (imem_addr !== 32'h14 || instr !== word_of(32'h10) || fetch_count !== 32'd5) begin
      bad++;
      $display("FAIL stall_release: got pc=%h instr=%h cnt=%0d want pc=14 instr=%h cnt=5",
               imem_addr, instr, fetch_count, word_of(32'h10));
    end
  endtask

  task automatic test_branch_stall();
    redirect(32'h0000_0020);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0, 26'h0);
    total++;
    if (imem_addr !== 32'h100 || valid !== 1'b0 || instr !== 32'h0 || instr_pc4 !== 32'h0 ||
        fetch_count !== 32'd5) begin
      bad++;
      $display("FAIL branch_stall: got pc=%h v=%b instr=%h pc4=%h cnt=%0d want pc=100 v=0 cnt=5",
               imem_addr, valid, instr, instr_pc4, fetch_count);
    end
    free_edge();
    total++;
    if (instr !== word_of(32'h100) || valid !== 1'b1 || imem_addr !== 32'h104) begin
      bad++;
      $display("FAIL branch_after: got instr=%h v=%b pc=%h want instr=%h v=1 pc=104", instr,
               valid, imem_addr, word_of(32'h100));
    end
  endtask

  task automatic test_jump();
    redirect(32'h4000_0008);
    step(1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0010);
    total++;
    if (imem_addr !== 32'h4000_0040 || valid !== 1'b0) begin
      bad++;
      $display("FAIL jump_target: got pc=%h v=%b want pc=40000040 v=0", imem_addr, valid);
    end
    step(1'b0, 1'b1, 32'h0000_0080, 1'b1, 26'h3FF_FFFF);
    total++;
    if (imem_addr !== 32'h80 || valid !== 1'b0 || fetch_count !== 32'd6) begin
      bad++;
      $display("FAIL branch_over_jump: got pc=%h v=%b cnt=%0d want pc=80 v=0 cnt=6", imem_addr,
               valid, fetch_count);
    end
    free_edge();
    total++;
    if (instr !== word_of(32'h80) || valid !== 1'b1 || fetch_count !== 32'd7) begin
      bad++;
      $display("FAIL jump_resume: got instr=%h v=%b cnt=%0d want instr=%h v=1 cnt=7", instr,
               valid, fetch_count, word_of(32'h80));
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    free_edge();
    total++;
    if (imem_addr !== 32'h0 || instr_pc4 !== 32'h0 || instr !== word_of(32'hFFFF_FFFC) ||
        fetch_count !== 32'd8) begin
      bad++;
      $display("FAIL pc_wrap: got pc=%h pc4=%h instr=%h cnt=%0d want pc=0 pc4=0 instr=%h cnt=8",
               imem_addr, instr_pc4, instr, fetch_count, word_of(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_async_reset();
    redirect(32'h0000_004C);
    free_edge();
    total++;
    if (imem_addr !== 32'h50 || valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got pc=%h v=%b want pc=50 v=1", imem_addr, valid);
    end
    #3;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({imem_addr, instr, instr_pc4, valid, fetch_count} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0})
    begin
      bad++;
      $display("FAIL async_reset: got pc=%h instr=%h pc4=%h v=%b cnt=%h want all zero",
               imem_addr, instr, instr_pc4, valid, fetch_count);
    end
    @(posedge clock);
    #1;
    total++;
    if (imem_addr !== 32'h0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got pc=%h v=%b want pc=0 v=0", imem_addr, valid);
    end
    reset = 1'b0;
    free_edge();
    total++;
    if (instr !== word_of(32'h0) || imem_addr !== 32'h4 || instr_pc4 !== 32'h4 ||
        fetch_count !== 32'd1 || valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_fetch: got instr=%h pc=%h pc4=%h cnt=%0d v=%b want instr=%h pc=4",
               instr, imem_addr, instr_pc4, fetch_count, valid, word_of(32'h0));
    end
    total++;
    if (instr2 !== word_of(32'h1000_0004) || instr_pc4_2 !== 32'h1000_0008) begin
      bad++;
      $display("FAIL reset_pc_fetch: got instr=%h pc4=%h want instr=%h pc4=10000008", instr2,
               instr_pc4_2, word_of(32'h1000_0004));
    end
  endtask

  task automatic test_random();
    logic s, b, j;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #2;
        model_reset();
        reset = 1'b0;
      end
      b = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0);
      step(s, b, $urandom, j, 26'($urandom));
      total++;
      if ({imem_addr, instr, instr_pc4, valid, fetch_count} !==
          {m_pc, m_instr, m_pc4, m_valid, m_cnt}) begin
        bad++;
        $display("FAIL rand[%0d]: got pc=%h instr=%h pc4=%h v=%b cnt=%h want pc=%h instr=%h pc4=%h v=%b cnt=%h",
                 i, imem_addr, instr, instr_pc4, valid, fetch_count, m_pc, m_instr, m_pc4,
                 m_valid, m_cnt);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_jump();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
